// File: rtl/instr_fetch_queue.sv
// Fetch stage ahead of the main decoder: issues sequential PC requests, queues
// in-order responses, and squashes younger work on a branch/jump redirect.
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [6:0]  opcode,
    input  logic        instr_ready
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned DSC_W = 16;

    logic [31:0]      r_pc;
    logic [31:0]      r_slot_instr [DEPTH];
    logic [31:0]      r_slot_pc    [DEPTH];
    logic [DEPTH-1:0] r_slot_filled;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W-1:0] r_fill_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_unfilled;
    logic [DSC_W-1:0] r_discard_cnt;

    logic             w_grant;
    logic             w_rsp_drop;
    logic             w_fill;
    logic             w_pop;
    logic [DSC_W-1:0] w_discard_next;
    logic             w_unused_rpc_lsb;

    assign w_unused_rpc_lsb = ^redirect_pc[1:0];

    assign imem_req   = (r_count < CNT_W'(DEPTH)) && !redirect_valid && !rst;
    assign imem_addr  = r_pc;
    assign w_grant    = imem_req && imem_gnt;
    assign w_rsp_drop = imem_rvalid && (r_discard_cnt != '0);
    assign w_fill     = imem_rvalid && (r_discard_cnt == '0) && (r_unfilled != '0);

    assign instr_valid = r_slot_filled[r_head] && !redirect_valid;
    assign w_pop       = instr_valid && instr_ready;
    assign instr       = instr_valid ? r_slot_instr[r_head] : 32'd0;
    assign instr_pc    = instr_valid ? r_slot_pc[r_head]    : 32'd0;
    assign opcode      = instr[6:0];

    // Unfilled slots become responses still owed by memory; a response landing
    // in the redirect cycle is consumed right away. Guarded against underflow.
    always_comb begin
        w_discard_next = r_discard_cnt + DSC_W'(r_unfilled);
        if (imem_rvalid && (w_discard_next != '0)) begin
            w_discard_next = w_discard_next - DSC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_head        <= '0;
            r_tail        <= '0;
            r_fill_ptr    <= '0;
            r_count       <= '0;
            r_unfilled    <= '0;
            r_slot_filled <= '0;
            r_discard_cnt <= '0;
        end else if (redirect_valid) begin
            r_pc          <= {redirect_pc[31:2], 2'b00};
            r_head        <= '0;
            r_tail        <= '0;
            r_fill_ptr    <= '0;
            r_count       <= '0;
            r_unfilled    <= '0;
            r_slot_filled <= '0;
            r_discard_cnt <= w_discard_next;
        end else begin
            if (w_grant) begin
                r_tail <= r_tail + PTR_W'(1);
                r_pc   <= r_pc + 32'd4;
            end
            if (w_rsp_drop) begin
                r_discard_cnt <= r_discard_cnt - DSC_W'(1);
            end
            // Fill and pop never hit the same slot: pop needs a filled head.
            if (w_fill) begin
                r_slot_filled[r_fill_ptr] <= 1'b1;
                r_fill_ptr                <= r_fill_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_slot_filled[r_head] <= 1'b0;
                r_head                <= r_head + PTR_W'(1);
            end
            r_count    <= r_count + CNT_W'(w_grant) - CNT_W'(w_pop);
            r_unfilled <= r_unfilled + CNT_W'(w_grant) - CNT_W'(w_fill);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !redirect_valid) begin
            if (w_grant) begin
                r_slot_pc[r_tail] <= r_pc;
            end
            if (w_fill) begin
                r_slot_instr[r_fill_ptr] <= imem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !redirect_valid && imem_rvalid) begin
            assert ((r_discard_cnt != '0) || (r_unfilled != '0))
                else $error("instr_fetch_queue: response with no outstanding request");
        end
    end

endmodule
